// File: rtl/in_ram_writer_pkg.sv
// Shared types and defaults for the input-RAM writer: FSM encoding, word/frame geometry,
// frame-counter width. No logic, so it adds no latency or backpressure of its own.
package in_ram_writer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int FCNT_W     = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_KICK  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/in_ram_wr_port.sv
// Registered input-RAM write stage: strobe, address and data one cycle after the handshake,
// with frame_err aligned to that strobe. Address/data hold when idle; never stalls.
module in_ram_wr_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_err,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              frame_err
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      frame_err   <= 1'b0;
    end else begin
      ram_wren  <= wr_en;
      frame_err <= wr_en & wr_err;
      if (wr_en) begin
        ram_address <= wr_addr;
        ram_data    <= wr_data;
      end
    end
  end

endmodule

// File: rtl/up_counter_4bit.sv
// 4-bit up counter with synchronous clear (clear wins over increment); 1-cycle update.
// No backpressure: it counts whatever inc pulses it is given.
module up_counter_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/in_ram_writer.sv
// Loads a 16-word frame into the input RAM (write 1 cycle after handshake), start 2 cycles after a good frame.
// s_ready is registered and drops from the final handshake until the controller's done is accepted.
module in_ram_writer
  import in_ram_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t            state;
  logic [3:0]        wptr_cnt;
  logic [ADDR_W-1:0] wptr;
  logic              hs;
  logic              last_slot;
  logic              frame_end;
  logic              frame_good;
  logic              frame_bad;

  assign wptr       = wptr_cnt;
  assign hs         = s_valid & s_ready;
  assign last_slot  = (wptr == ADDR_W'(DEPTH - 1));
  // A frame ends on s_last or on filling the last slot; only both together is a good frame.
  assign frame_end  = hs & (s_last | last_slot);
  assign frame_good = hs & s_last & last_slot;
  assign frame_bad  = frame_end & ~frame_good;

  up_counter_4bit u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_end),
    .inc   (hs),
    .count (wptr_cnt)
  );

  in_ram_wr_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (hs),
    .wr_addr     (wptr),
    .wr_data     (s_data),
    .wr_err      (frame_bad),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .frame_err   (frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_LOAD;
      s_ready   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (frame_good) begin
            state   <= ST_FLUSH;
            s_ready <= 1'b0;
            busy    <= 1'b1;
          end else begin
            s_ready <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state <= ST_KICK;
          start <= 1'b1;
        end
        ST_KICK: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state     <= ST_LOAD;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_LOAD;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  a_start_single : assert property (@(posedge clk) disable iff (!rst) start |=> !start);
  a_ready_idle   : assert property (@(posedge clk) disable iff (!rst) s_ready |-> !busy);

endmodule

// File: tb/tb_in_ram_writer.sv
// Randomized and directed stimulus for in_ram_writer, checked cycle by cycle against a frame-level model.
module tb_in_ram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        ram_wren;
  logic [3:0]  ram_address;
  logic [15:0] ram_data;
  logic        start;
  logic        done = 1'b0;
  logic        busy;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  in_ram_writer dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] data;
    bit          err;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  // Frame-level model: position within current frame, blocked flag, scheduled events.
  int          pos = 0;
  bit          mbusy = 0;
  int          fcnt = 0;
  int          start_cyc = -100;
  int          pending_busy = -100;
  int          release_cyc = -100;
  int          last_addr = 0;
  logic [15:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    pos = 0; mbusy = 0; fcnt = 0;
    start_cyc = -100; pending_busy = -100; release_cyc = -100;
    last_addr = 0; last_data = '0;
  endtask

  task automatic check_outputs();
    bit  have;
    wr_t w;
    have = 0;
    if (cyc == pending_busy) mbusy = 1;
    if (cyc == release_cyc) begin
      mbusy = 0;
      fcnt = (fcnt + 1) % 256;
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      w = exp_q.pop_front();
      have = 1;
      last_addr = w.addr;
      last_data = w.data;
    end
    chk("ram_wren", {31'd0, ram_wren}, {31'd0, have});
    chk("ram_address", {28'd0, ram_address}, last_addr);
    chk("ram_data", {16'd0, ram_data}, {16'd0, last_data});
    chk("frame_err", {31'd0, frame_err}, {31'd0, have && w.err});
    chk("start", {31'd0, start}, {31'd0, cyc == start_cyc});
    chk("busy", {31'd0, busy}, {31'd0, mbusy});
    chk("s_ready", {31'd0, s_ready}, {31'd0, !mbusy});
    chk("frame_cnt", {24'd0, frame_cnt}, fcnt);
  endtask

  // One clock cycle: drive inputs, advance the model, then sample the next cycle's outputs.
  task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit dn);
    wr_t w;
    s_valid = v; s_data = d; s_last = l; done = dn;
    if (v && !mbusy) begin
      w.cyc = cyc + 1; w.addr = pos; w.data = d; w.err = 0;
      if (l && pos == 15) begin
        start_cyc = cyc + 2;
        pending_busy = cyc + 1;
      end else if (l || pos == 15) begin
        w.err = 1;
      end
      pos = (l || pos == 15) ? 0 : pos + 1;
      exp_q.push_back(w);
    end
    if (dn && mbusy && cyc > start_cyc) release_cyc = cyc + 1;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic send_frame(input int n, input int last_at, input int base, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) cycle(0, 16'hdead, 1, 0);
      cycle(1, 16'(base + i), i == last_at, 0);
    end
  endtask

  // Waits until the writer has been in WAIT for `extra` cycles, then pulses done.
  task automatic finish_frame(input int extra, input bit hold_valid);
    int k;
    for (k = 0; k < 300 && !(mbusy && cyc > start_cyc + extra); k++)
      cycle(hold_valid, 16'($urandom), 0, 0);
    chk("wait_bound", {31'd0, mbusy && cyc > start_cyc + extra}, 32'd1);
    cycle(hold_valid, 16'($urandom), 0, 1);
  endtask

  task automatic reset_checks();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_ram_address", {28'd0, ram_address}, 32'd0);
    chk("rst_ram_data", {16'd0, ram_data}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b0; s_valid = 1'b0; done = 1'b0;
    #1;
    reset_checks();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    // done right after release lands in LOAD and must be ignored
    cycle(0, 16'h0, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    reset_pulse();

    // Good frame 0x0001..0x0010, then 20 cycles of held s_valid while waiting for done.
    send_frame(16, 15, 1, 0);
    finish_frame(20, 1);
    send_frame(16, 15, 16'h100, 0);
    finish_frame(0, 0);

    // Short frame, long frame, then a good frame starting at address 0.
    send_frame(5, 4, 16'h200, 0);
    send_frame(16, -1, 16'h300, 0);
    send_frame(16, 15, 16'h400, 0);
    finish_frame(2, 0);

    // Gapped input.
    send_frame(16, 15, 16'h500, 1);
    finish_frame(1, 1);

    // Randomized traffic with random done pulses.
    for (int i = 0; i < 2000; i++) begin
      bit l;
      l = (pos == 15) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 39) == 0);
      cycle($urandom_range(0, 9) < 7, 16'($urandom), l, $urandom_range(0, 4) == 0);
    end
    if (mbusy) finish_frame(0, 0);

    // Frame counter wrap across 256 more frames.
    for (int f = 0; f < 256; f++) begin
      send_frame(16, 15, f * 16, 0);
      finish_frame(0, 0);
    end

    // Reset while in WAIT, then a stray done.
    send_frame(16, 15, 16'h600, 0);
    while (cyc <= start_cyc + 1) cycle(0, 16'h0, 0, 0);
    reset_pulse();
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 0);
    send_frame(16, 15, 16'h700, 0);
    finish_frame(0, 0);
    repeat (3) cycle(0, 16'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
